// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_LENGTH   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_CHECKSUM = 2'd3
    } err_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam int          LEN_BYTES = 2;
    localparam int          LEN_W     = 8 * LEN_BYTES;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] idx);
        return {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input channel plus instruction memory write port of the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Collects four bytes little-endian into a 32-bit word; word_valid_o fires
// combinationally with the fourth byte so the write can be registered next edge.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  lane_q;
    logic [23:0] buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            buf_q  <= 24'd0;
        end else if (clear_i) begin
            lane_q <= 2'd0;
            buf_q  <= 24'd0;
        end else if (byte_valid_i) begin
            lane_q <= lane_q + 2'd1;
            // Shifting right places byte k at bits [8k+7:8k] once three bytes are in.
            buf_q  <= {byte_i, buf_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, buf_q};
endmodule

// File: rtl/imem_loader.sv
// Boot loader: LEN_LO, LEN_HI, 4N payload bytes -> consecutive imem word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  MEM_SIZE       = 128,
    parameter int  TIMEOUT_CYCLES = 65535,
    parameter bit  HOLD_AT_RESET  = 1'b1,
    localparam int ADDR_WIDTH     = $clog2(MEM_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    imem_loader_if.slave        bus,
    output logic                cpu_hold_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_code_o,
    output logic [ADDR_WIDTH:0] words_loaded_o
);
    localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    err_t                err_q;
    logic                active_q;
    logic                mem_we_q;
    logic                done_q;
    logic                cpu_hold_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [ADDR_WIDTH:0] words_q;
    logic [LEN_W-1:0]    len_q;
    logic [CNT_W-1:0]    idle_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic             accept;
    logic             start_ok;
    logic             word_valid;
    logic [31:0]      word;
    logic             last_word;
    logic             timed_out;
    logic [LEN_W-1:0] len_rx;

    // active_q is the single registered source of rx_ready/busy, so readiness never sees rx_valid.
    assign accept    = bus.rx_valid && active_q;
    assign start_ok  = (state_q == IDLE) && start_i;
    assign len_rx    = {bus.rx_data, len_q[7:0]};
    assign last_word = (LEN_W'(words_q) + LEN_W'(1)) == len_q;
    assign timed_out = active_q && !accept && (idle_q == IDLE_LIMIT);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (bus.rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_q       <= ERR_NONE;
            active_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            cpu_hold_q  <= HOLD_AT_RESET;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            words_q     <= '0;
            len_q       <= '0;
            idle_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            if (accept || start_ok) begin
                idle_q <= '0;
            end else if (active_q) begin
                idle_q <= idle_q + 1'b1;
            end

            if (timed_out) begin
                err_q    <= ERR_TIMEOUT;
                state_q  <= IDLE;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            err_q      <= ERR_NONE;
                            words_q    <= '0;
                            cpu_hold_q <= 1'b1;
                            state_q    <= LEN_LO;
                            active_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q     <= 8'd0;
`endif
                        end
                    end
                    LEN_LO: begin
                        if (accept) begin
                            len_q[7:0] <= bus.rx_data;
                            state_q    <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (accept) begin
                            len_q <= len_rx;
                            if (len_rx == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q  <= CSUM;
`else
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                active_q <= 1'b0;
`endif
                            end else if (len_rx > LEN_W'(MEM_SIZE)) begin
                                err_q    <= ERR_LENGTH;
                                state_q  <= IDLE;
                                active_q <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q <= csum_q + bus.rx_data;
`endif
                            if (word_valid) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= word_byte_addr(32'(words_q));
                                mem_wdata_q <= word;
                                words_q     <= words_q + 1'b1;
                                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_q  <= CSUM;
`else
                                    state_q  <= DONE;
                                    done_q   <= 1'b1;
                                    active_q <= 1'b0;
`endif
                                end
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (accept) begin
                            active_q <= 1'b0;
                            if (bus.rx_data == csum_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                err_q   <= ERR_CHECKSUM;
                                state_q <= IDLE;
                            end
                        end
                    end
`endif
                    DONE: begin
                        cpu_hold_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready   = active_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign busy_o         = active_q;
    assign done_o         = done_q;
    assign err_code_o     = err_q;
    assign words_loaded_o = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a forked monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int TO = 100;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_i = 1'b0;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] err_code;
    logic [7:0] words_loaded;

    int checks    = 0;
    int errors    = 0;
    int n_writes  = 0;
    int n_done    = 0;
    int n_done_we = 0;
    logic [63:0] exp_q[$];

    imem_loader_if bus();

    imem_loader #(
        .MEM_SIZE       (128),
        .TIMEOUT_CYCLES (TO),
        .HOLD_AT_RESET  (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .bus            (bus),
        .cpu_hold_o     (cpu_hold),
        .busy_o         (busy),
        .done_o         (done),
        .err_code_o     (err_code),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (bus.mem_we === 1'b1) n_done_we++;
            end
            if (bus.mem_we === 1'b1) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", bus.mem_addr, e[63:32]);
                    chk("write_data", bus.mem_wdata, e[31:0]);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: byte %h not accepted, got ready %b expected 1", b, bus.rx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        logic [7:0] f[$];
        int w0, d0, dw0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: got no finish expected finish");
                $fatal(1);
            end
        join_none

        // Reset values
        #12;
        chk("rst_rx_ready", 32'(bus.rx_ready), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_code), 0);
        chk("rst_words", 32'(words_loaded), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);

        // N=2 gapless session
        f = '{8'h02, 8'h00, 8'h93, 8'h04, 8'h40, 8'h00, 8'h13, 8'h04, 8'h40, 8'h00};
        if (CSUM_EN) f.push_back(8'h2E);
        push_wr(32'h0, 32'h0040_0493);
        push_wr(32'h4, 32'h0040_0413);
        w0 = n_writes; d0 = n_done; dw0 = n_done_we;
        do_start();
        chk("start_hold", 32'(cpu_hold), 1);
        chk("start_busy", 32'(busy), 1);
        send_q(f);
        @(negedge clk);
        chk("done_pulse", 32'(done), 1);
        chk("hold_during_done", 32'(cpu_hold), 1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("hold_released", 32'(cpu_hold), 0);
        chk("busy_after_done", 32'(busy), 0);
        cyc(2);
        chk("n2_words", 32'(words_loaded), 2);
        chk("n2_err", 32'(err_code), 0);
        chk("n2_writes", 32'(n_writes - w0), 2);
        chk("n2_dones", 32'(n_done - d0), 1);
        chk("done_with_last_we", 32'(n_done_we - dw0), CSUM_EN ? 0 : 1);
        chk("addr_holds", bus.mem_addr, 32'h4);
        chk("wdata_holds", bus.mem_wdata, 32'h0040_0413);

        // Length too large
        w0 = n_writes;
        do_start();
        send_q('{8'h81, 8'h00});
        @(negedge clk);
        chk("len_err", 32'(err_code), 1);
        chk("len_busy", 32'(busy), 0);
        chk("len_ready", 32'(bus.rx_ready), 0);
        chk("len_hold", 32'(cpu_hold), 1);
        cyc(2);
        chk("len_writes", 32'(n_writes - w0), 0);

        // N=MEM_SIZE is legal; start also clears the sticky error
        do_start();
        chk("start_clears_len_err", 32'(err_code), 0);
        send_q('{8'h80, 8'h00});
        @(negedge clk);
        chk("max_len_busy", 32'(busy), 1);
        chk("max_len_err", 32'(err_code), 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(1);

        // Timeout after two payload bytes
        w0 = n_writes;
        do_start();
        send_q('{8'h01, 8'h00, 8'h93, 8'h04});
        cyc(TO - 2);
        chk("no_early_timeout", 32'(err_code), 0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_timeout", 32'(busy), 1);
        @(negedge clk);
        chk("timeout_err", 32'(err_code), 2);
        chk("timeout_busy", 32'(busy), 0);
        chk("timeout_hold", 32'(cpu_hold), 1);
        chk("timeout_writes", 32'(n_writes - w0), 0);
        cyc(1);
        do_start();
        chk("start_clears_timeout", 32'(err_code), 0);

        // Gapped stream with stray start pulses, continuing the session just started
        f = '{8'h02, 8'h00, 8'h93, 8'h04, 8'h40, 8'h00, 8'h13, 8'h04, 8'h40, 8'h00};
        if (CSUM_EN) f.push_back(8'h2E);
        push_wr(32'h0, 32'h0040_0493);
        push_wr(32'h4, 32'h0040_0413);
        w0 = n_writes; d0 = n_done;
        for (int i = 0; i < f.size(); i++) begin
            bus.rx_valid = 1'b0;
            if (i % 3 == 2) do_start();
            else cyc(1 + (i % 2));
            send(f[i]);
            if (i == 6) chk("gap_words_mid", 32'(words_loaded), 1);
        end
        bus.rx_valid = 1'b0;
        cyc(3);
        chk("gap_words", 32'(words_loaded), 2);
        chk("gap_writes", 32'(n_writes - w0), 2);
        chk("gap_dones", 32'(n_done - d0), 1);
        chk("gap_err", 32'(err_code), 0);
        chk("gap_hold", 32'(cpu_hold), 0);

        // N=0: no writes, still completes
        w0 = n_writes; d0 = n_done;
        f = '{8'h00, 8'h00};
        if (CSUM_EN) f.push_back(8'h00);
        do_start();
        send_q(f);
        @(negedge clk);
        chk("n0_done", 32'(done), 1);
        cyc(2);
        chk("n0_writes", 32'(n_writes - w0), 0);
        chk("n0_words", 32'(words_loaded), 0);
        chk("n0_hold", 32'(cpu_hold), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: word is written, then error and no done
        w0 = n_writes; d0 = n_done;
        push_wr(32'h0, NOP);
        do_start();
        send_q('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00});
        @(negedge clk);
        chk("csum_err", 32'(err_code), 3);
        chk("csum_busy", 32'(busy), 0);
        cyc(2);
        chk("csum_no_done", 32'(n_done - d0), 0);
        chk("csum_hold", 32'(cpu_hold), 1);
        chk("csum_writes", 32'(n_writes - w0), 1);
        chk("csum_words", 32'(words_loaded), 1);
`endif

        // Reset mid-session after six payload bytes
        push_wr(32'h0, 32'h0040_0493);
        do_start();
        send_q('{8'h02, 8'h00, 8'h93, 8'h04, 8'h40, 8'h00, 8'h13, 8'h04});
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(bus.mem_we), 0);
        chk("abort_ready", 32'(bus.rx_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_hold", 32'(cpu_hold), 1);
        chk("abort_words", 32'(words_loaded), 0);
        chk("abort_addr", bus.mem_addr, 0);
        chk("abort_wdata", bus.mem_wdata, 0);
        chk("abort_err", 32'(err_code), 0);
        #3;
        rst_n = 1'b1;
        cyc(1);

        f = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        if (CSUM_EN) f.push_back(8'h64);
        push_wr(32'h0, 32'h1122_3344);
        push_wr(32'h4, 32'h5566_7788);
        d0 = n_done;
        do_start();
        send_q(f);
        cyc(3);
        chk("post_rst_dones", 32'(n_done - d0), 1);
        chk("post_rst_words", 32'(words_loaded), 2);
        chk("post_rst_hold", 32'(cpu_hold), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that streams a program into the instruction memory write port over a byte-wide valid/ready channel (UART or debug bridge). It assembles little-endian 32-bit words and issues one write per word at consecutive word-aligned addresses. It holds the core stalled until a load completes cleanly. It sits between the host byte link and the instruction memory, next to the fetch stage.

## Interface
- MEM_SIZE, 128, instruction memory depth in 32-bit words; ADDR_WIDTH = $clog2(MEM_SIZE) derived locally
- TIMEOUT_CYCLES, 65535, max idle cycles between accepted bytes during a session
- HOLD_AT_RESET, 1, reset value of cpu_hold
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a session when IDLE, ignored otherwise
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  32  byte address, always word-aligned (bits [1:0] = 0)
- mem_wdata  out  32  word to write
- cpu_hold  out  1  stall/reset request to the core
- busy  out  1  session in progress
- done  out  1  one-cycle pulse on successful completion
- err_code  out  2  0 none, 1 length, 2 timeout, 3 checksum; sticky until next accepted start
- words_loaded  out  ADDR_WIDTH+1  words written in current/last session

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N payload bytes (little-endian words), then optional checksum byte (see Configuration).
- States: IDLE -> LEN_LO -> LEN_HI -> DATA -> [CSUM] -> DONE -> IDLE; any error -> IDLE.
- IDLE: rx_ready=0, busy=0. start clears err_code, words_loaded, byte index, and checksum, sets cpu_hold=1, then enters LEN_LO.
- LEN_LO/LEN_HI/DATA/CSUM: rx_ready=1, busy=1.
- After LEN_HI: N=0 -> DONE (no writes). N>MEM_SIZE -> err_code=1, IDLE. Otherwise DATA.
- DATA: byte k of word i goes into bits [8k+7:8k]. On the 4th byte, mem_we=1 in the next cycle with mem_addr=i*4, and words_loaded increments in that same cycle. After word N-1, go to CSUM or DONE.
- DONE: done=1 for exactly one cycle, cpu_hold->0 on exit, return to IDLE.
- Error: return to IDLE. cpu_hold stays 1. Words already written remain in memory.
- Timeout: idle counter resets on every accepted byte and on start. If it reaches TIMEOUT_CYCLES in any active state, set err_code=2 and go to IDLE.
- mem_addr/mem_wdata hold their last value when mem_we=0.

## Timing
- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold HOLD_AT_RESET, busy 0, done 0, err_code 0, words_loaded 0.
- rx_ready is a registered function of state only; it never depends combinationally on rx_valid.
- Write latency: 1 cycle from acceptance of a word's last byte to mem_we.
- Back-to-back bytes are accepted every cycle. A write cycle never stalls acceptance.
- Last word with no checksum: the final mem_we and done occur in the same cycle. cpu_hold falls the following cycle.
- start together with rx_valid in IDLE: the session starts and the byte is NOT consumed.
- start during a session: ignored, with no effect on counters.
- rst_n asserted mid-session: immediate abort to reset values. A partial word is discarded and mem_we is deasserted asynchronously.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: CSUM state present. It expects one byte equal to the 8-bit modulo-256 sum of all payload bytes (length bytes excluded).
  - Match -> DONE.
  - Mismatch -> err_code=3, IDLE, cpu_hold stays 1.
  - N=0 still requires a checksum byte of 0x00.
- Undefined: no CSUM state; DATA goes directly to DONE; err_code never reads 3.

## Structure
- imem_loader_pkg holds:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE)
  - err_code enum
  - NOP constant 32'h00000013
  - LEN_BYTES=2
- One sub-module, imem_word_packer: byte lane counter plus 32-bit shift/insert register. It outputs word_valid and word, and has a clear input.

## Test plan
- N=2, bytes 93 04 40 00 | 13 04 40 00 (add checksum 0x2E if EN) -> mem_we at addr 0x0 data 0x00400493 and at 0x4 data 0x00400413; done pulse; cpu_hold 1→0; words_loaded=2.
- N=MEM_SIZE+1 (0x81,0x00) -> err_code=1 after LEN_HI, zero writes, cpu_hold=1, busy=0.
- N=1, send 2 payload bytes then stall TIMEOUT_CYCLES -> err_code=2, no mem_we, IDLE; a new start clears err_code to 0.
- EN build, N=1 word 0x00000013 with checksum 0x00 -> mem_we addr 0 data 0x00000013, then err_code=3, no done, cpu_hold=1.
- rx_valid held high with gaps of rx_valid=0 between bytes, plus start pulses mid-session -> same writes as gapless case; extra starts ignored.
- rst_n pulsed low after 6 payload bytes -> all outputs at reset values; a subsequent full session writes from addr 0.
